// File: rtl/rotating_sqr_ctrl.sv
// Purpose: rotating-square sequencer; step timer, 16-position tracker, 8-digit display scan.
// Latency: seg_sel/seg_led are registered, one cycle behind digit index and position.
// Backpressure: none; en pauses rotation only, the scan always runs.
module rotating_sqr_ctrl #(
    parameter int STEP_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rot,
    output logic       step_tick,
    output logic [3:0] pos,
    output logic [7:0] seg_sel,
    output logic [7:0] seg_led
);

    // Counter widths; both dividers are at least 2 so $clog2 is never 0.
    localparam int SW = $clog2(STEP_DIV);
    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}; dp never lit.
    localparam logic [7:0] PAT_UPPER = 8'h9C;   // a,b,f,g
    localparam logic [7:0] PAT_LOWER = 8'hA3;   // c,d,e,g
    localparam logic [7:0] PAT_BLANK = 8'hFF;

    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [3:0]    pos_q, pos_d;
    logic          step_tick_q, step_tick_d;
    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic [7:0]    seg_sel_q, seg_sel_d;
    logic [7:0]    seg_led_q, seg_led_d;
    logic          step_fire;

    // Step timer: counts only while enabled, holds while paused; terminal count fires a step.
    always_comb begin
        step_cnt_d = step_cnt_q;
        step_fire  = 1'b0;
        if (en) begin
            if (step_cnt_q == STEP_LAST) begin
                step_cnt_d = '0;
                step_fire  = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
        end
    end

    // Position update: rot is only looked at on the step edge; 4-bit arithmetic wraps naturally.
    always_comb begin
        pos_d       = pos_q;
        step_tick_d = step_fire;
        if (step_fire) begin
            if (rot) begin
                pos_d = pos_q - 4'd1;
            end else begin
                pos_d = pos_q + 4'd1;
            end
        end
    end

    // Digit scan: free-running slot timer, digit index advances 0..7 and wraps.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        dig_d      = dig_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            dig_d      = dig_q + 3'd1;
        end
    end

    // Pattern decode from current digit and position; upper row on digit p,
    // lower row (p>=8) on digit 15-p, which is the inverted low three bits of p.
    always_comb begin
        seg_sel_d = ~(8'b1 << dig_q);
        seg_led_d = PAT_BLANK;
        if (!pos_q[3] && (dig_q == pos_q[2:0])) begin
            seg_led_d = PAT_UPPER;
        end else if (pos_q[3] && (dig_q == ~pos_q[2:0])) begin
            seg_led_d = PAT_LOWER;
        end
    end

    // State and output registers; every flop returns to its reset value at once on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt_q  <= '0;
            pos_q       <= 4'd0;
            step_tick_q <= 1'b0;
            scan_cnt_q  <= '0;
            dig_q       <= 3'd0;
            seg_sel_q   <= 8'hFF;
            seg_led_q   <= 8'hFF;
        end else begin
            step_cnt_q  <= step_cnt_d;
            pos_q       <= pos_d;
            step_tick_q <= step_tick_d;
            scan_cnt_q  <= scan_cnt_d;
            dig_q       <= dig_d;
            seg_sel_q   <= seg_sel_d;
            seg_led_q   <= seg_led_d;
        end
    end

    assign step_tick = step_tick_q;
    assign pos       = pos_q;
    assign seg_sel   = seg_sel_q;
    assign seg_led   = seg_led_q;

endmodule

// File: tb/tb_rotating_sqr_ctrl.sv
// Purpose: directed bench for rotating_sqr_ctrl (STEP_DIV=4 with SCAN_DIV=2 and SCAN_DIV=4).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; inputs driven from a single linear initial block.
module tb_rotating_sqr_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rot;

    logic       a_tick, b_tick;
    logic [3:0] a_pos, b_pos;
    logic [7:0] a_sel, b_sel;
    logic [7:0] a_led, b_led;

    int n_cmp;
    int n_err;
    int k;          // rising edges since reset release

    rotating_sqr_ctrl #(.STEP_DIV(4), .SCAN_DIV(2)) u_a (
        .clk(clk), .rst(rst), .en(en), .rot(rot),
        .step_tick(a_tick), .pos(a_pos), .seg_sel(a_sel), .seg_led(a_led)
    );

    rotating_sqr_ctrl #(.STEP_DIV(4), .SCAN_DIV(4)) u_b (
        .clk(clk), .rst(rst), .en(en), .rot(rot),
        .step_tick(b_tick), .pos(b_pos), .seg_sel(b_sel), .seg_led(b_led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic wait_until(input int target);
        while (k < target) edge1();
    endtask

    // Scan frame on u_a with pos frozen: digit shown after edge kk is ((kk-1)/2)%8.
    task automatic frame(input string tag, input int lit_dig, input logic [7:0] lit_pat);
        int d;
        for (int i = 0; i < 16; i++) begin
            edge1();
            d = ((k - 1) / 2) % 8;
            chk({tag, "_sel"}, a_sel, ~(8'b1 << d));
            chk({tag, "_led"}, a_led, (d == lit_dig) ? lit_pat : 8'hFF);
        end
    endtask

    initial begin
        int m;
        logic [7:0] exp_led;
        n_cmp = 0;
        n_err = 0;
        k     = 0;
        rst   = 1'b0;
        en    = 1'b0;
        rot   = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_sel", a_sel, 8'hFF);
        chk("rst_led", a_led, 8'hFF);
        chk("rst_pos", {4'h0, a_pos}, 8'h00);
        chk("rst_tick", {7'h0, a_tick}, 8'h00);

        en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        k = 0;

        // First cycle after release.
        edge1();
        chk("rel_sel", a_sel, 8'hFE);
        chk("rel_led", a_led, 8'h9C);
        chk("rel_pos", {4'h0, a_pos}, 8'h00);

        // Forward run: tick on every 4th edge, pos 1..15,0. u_b checks coincident step/scan.
        for (m = 1; m <= 16; m++) begin
            wait_until(4 * m - 1);
            chk("fwd_pre_tick", {7'h0, a_tick}, 8'h00);
            edge1();
            chk("fwd_tick", {7'h0, a_tick}, 8'h01);
            chk("fwd_pos", {4'h0, a_pos}, 8'((m) % 16));
            edge1();
            chk("fwd_post_tick", {7'h0, a_tick}, 8'h00);
            if (m < 8 || m == 16) exp_led = 8'h9C;
            else                  exp_led = 8'hFF;
            chk("sim_sel", b_sel, ~(8'b1 << (m % 8)));
            chk("sim_led", b_led, exp_led);
        end
        wait_until(64);
        chk("fwd_wrap_pos", {4'h0, a_pos}, 8'h00);

        // Reverse from 0, then rot toggles between steps.
        rot = 1'b1;
        wait_until(68);
        chk("rev_pos_15", {4'h0, a_pos}, 8'h0F);
        wait_until(72);
        chk("rev_pos_14", {4'h0, a_pos}, 8'h0E);
        wait_until(74);
        rot = 1'b0;
        wait_until(76);
        chk("rev_tog_fwd", {4'h0, a_pos}, 8'h0F);
        wait_until(77);
        rot = 1'b1;
        wait_until(80);
        chk("rev_tog_back", {4'h0, a_pos}, 8'h0E);
        wait_until(81);
        rot = 1'b0;
        wait_until(82);
        rot = 1'b1;
        wait_until(84);
        chk("rev_glitch", {4'h0, a_pos}, 8'h0D);

        // Pause after two counted cycles, hold for 10 edges.
        wait_until(86);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            edge1();
            chk("pause_tick", {7'h0, a_tick}, 8'h00);
            chk("pause_pos", {4'h0, a_pos}, 8'h0D);
            chk("pause_scan", a_sel, ~(8'b1 << (((k - 1) / 2) % 8)));
        end
        en = 1'b1;
        edge1();
        chk("resume_tick0", {7'h0, a_tick}, 8'h00);
        edge1();
        chk("resume_tick1", {7'h0, a_tick}, 8'h01);
        chk("resume_pos", {4'h0, a_pos}, 8'h0C);

        // pos=12: lower square on digit 3.
        en = 1'b0;
        frame("scan12", 3, 8'hA3);

        // Reverse to pos=8: lower square on digit 7.
        en = 1'b1;
        wait_until(130);
        chk("pos8", {4'h0, a_pos}, 8'h08);
        en = 1'b0;
        frame("scan8", 7, 8'hA3);

        // Reverse to pos=3: upper square on digit 3.
        en = 1'b1;
        wait_until(166);
        chk("pos3", {4'h0, a_pos}, 8'h03);
        en = 1'b0;
        frame("scan3", 3, 8'h9C);

        // Reset mid-cycle with a step_tick pending.
        en = 1'b1;
        wait_until(186);
        chk("pre_rst_tick", {7'h0, a_tick}, 8'h01);
        chk("pre_rst_pos", {4'h0, a_pos}, 8'h02);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tick", {7'h0, a_tick}, 8'h00);
        chk("mid_rst_pos", {4'h0, a_pos}, 8'h00);
        chk("mid_rst_sel", a_sel, 8'hFF);
        chk("mid_rst_led", a_led, 8'hFF);
        @(posedge clk);
        #1 rst = 1'b0;
        edge1();
        chk("rel2_sel", a_sel, 8'hFE);
        chk("rel2_led", a_led, 8'h9C);
        chk("rel2_tick", {7'h0, a_tick}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rotating_sqr_ctrl.md
Name: rotating_sqr_ctrl

Overview:
- Sequencer for the rotating-square seven-segment demo.
- Generates the rotation step tick and tracks square position over 16 positions: upper square left→right across 8 digits, lower square right→left.
- Supports direction control and pause.
- Time-multiplexes the 8-digit display, driving the active-low digit select and segment pattern for the scanned digit.
- Sits between board controls (en, rot) and the seven-segment pins.

Parameters:
- STEP_DIV, 50_000_000, clk cycles per rotation step (0.25 s at 200 MHz); legal ≥2.
- SCAN_DIV, 50_000, clk cycles per digit scan slot (250 µs at 200 MHz); legal ≥2.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  1 = rotation advances; 0 = rotation paused, scanning continues.
- rot  input  1  direction: 0 = forward (pos+1), 1 = reverse (pos−1).
- step_tick  output  1  one-cycle pulse per rotation step.
- pos  output  4  current square position 0..15.
- seg_sel  output  8  active-low digit select; bit i low = digit i driven.
- seg_led  output  8  active-low segments {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (async assert, sync release): all counters 0, pos=0, digit index=0, step_tick=0, seg_sel=8'hFF, seg_led=8'hFF.

Step counter:
- Width is $clog2(STEP_DIV).
- Increments only while en=1; holds its value (not cleared) while en=0.
- At STEP_DIV-1 with en=1: counter→0 and pos advances on the same edge.
- step_tick is registered: it is high for exactly the one cycle following that edge.

pos arithmetic:
- 4-bit modulo-16.
- rot=0: 15→0 wrap. rot=1: 0→15 wrap.
- rot is sampled only at the step edge; rot changes between steps have no effect until the next step.
- en falling on the same edge as the terminal count: the step still occurs, because en was sampled high.

Scan counter:
- Free-running, independent of en, width $clog2(SCAN_DIV).
- At SCAN_DIV-1: counter→0 and digit index (3-bit) increments, 7→0 wrap.

Pattern decode (combinational from digit index d and pos p):
- p<8 and d==p: upper square (a,b,f,g lit), seg_led=8'h9C.
- p≥8 and d==15-p: lower square (c,d,e,g lit), seg_led=8'hA3.
- Otherwise: blank, 8'hFF.
- dp is always off.

Output registering:
- seg_sel = ~(8'b1<<d) and seg_led are registered.
- They reflect d and p from the previous cycle: 1-cycle latency after a digit index or pos change.
- First cycle after reset release: seg_sel=8'hFE, seg_led=8'h9C.
- Coincident digit advance and pos advance: the output on the next cycle uses both new values. No glitch state is permitted.

Reset mid-operation:
- All state returns immediately, asynchronously, to the reset values.
- A pending step_tick is dropped.

Test Plan:
- Reset (STEP_DIV=4, SCAN_DIV=2): assert rst mid-cycle → seg_sel=FF, seg_led=FF, pos=0, step_tick=0 immediately. Release → next cycle seg_sel=FE, seg_led=9C.
- Forward run (en=1, rot=0): step_tick once every 4 cycles; pos counts 0,1,…,15,0. After 16 ticks pos=0.
- Reverse (rot=1 from pos=0): next tick pos=15, then 14. Toggling rot mid-interval changes only the following step's direction.
- Pause (en=0 after 2 counted cycles, hold 10 cycles, re-enable): no step_tick and pos constant while paused; tick occurs 2 cycles after re-enable. Scan continues throughout.
- Scan decode: pos=3 → over one 16-cycle scan frame, only seg_sel=F7 carries seg_led=9C, all other digits FF. pos=12 → seg_sel=F7 carries A3. pos=8 → seg_sel=7F carries A3.
- Simultaneous step and scan edge (STEP_DIV=4, SCAN_DIV=4, counters aligned): next-cycle output uses the new pos and new digit together, with no intermediate pattern.
